// File: rtl/clock_edge_monitor.sv
// clock_edge_monitor
// Samples a slow toggling signal in the fast clk domain. It produces a
// one-cycle tick on each synchronized rising edge and measures the slow
// period in clk cycles. It also reports locked/timeout status, so that
// downstream logic can stay on clk and use enables.
// Optional build macro: CLOCK_EDGE_MONITOR_FALL_EN enables the tick_fall
// pulse on synchronized falling edges. Without it, tick_fall is tied to 0.
module clock_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 10000000,
  parameter int CW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slow_in,
  output logic          tick,
  output logic          tick_fall,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;
  logic                   s_d_p1;
  logic                   rise;
  logic [CW-1:0]          cnt_p1;
  logic                   at_limit;

  // ---- stage p0: metastability synchronizer on the asynchronous input
  // Shift slow_in through the synchronizer chain; the last flop is s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], slow_in};
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // ---- stage p1: edge detection against the previous synchronized level
  // Keep s delayed by one cycle so that rises and falls become single-cycle terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_p1 <= 1'b0;
    end else begin
      s_d_p1 <= s_p0;
    end
  end

  assign rise     = s_p0 & ~s_d_p1;
  assign at_limit = (cnt_p1 == CNT_MAX);

  // Counter of clk cycles since the last rise. It saturates so that a
  // missing edge is seen as a stable timeout condition and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (rise) begin
      cnt_p1 <= '0;
    end else if (!at_limit) begin
      cnt_p1 <= cnt_p1 + CNT_ONE;
    end
  end

  // ---- stage p2: registered status outputs
  // Lock FSM. All outputs are registered here and update on the same edge as tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tick         <= rise;
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The first rise is only a reference point. There is no period yet.
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            state        <= LOCKED;
            period       <= cnt_p1 + CNT_ONE;
            period_valid <= 1'b1;
            locked       <= 1'b1;
          end else if (at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end
        end
        LOCKED: begin
          // A rise on the saturation cycle wins over the timeout.
          if (rise) begin
            period       <= cnt_p1 + CNT_ONE;
            period_valid <= 1'b1;
          end else if (at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLOCK_EDGE_MONITOR_FALL_EN
  logic fall;

  assign fall = ~s_p0 & s_d_p1;

  // Falling-edge pulse. It has the same latency as tick and does not feed the counter or the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_fall <= 1'b0;
    end else begin
      tick_fall <= fall;
    end
  end
`else
  assign tick_fall = 1'b0;
`endif

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Testbench for clock_edge_monitor (SYNC_STAGES=2, TIMEOUT=64, CW=32).
// The reference model works on edge timestamps. A rise of slow_in that is
// sampled at edge n is reported after edge n+SYNC. A period is the distance
// between the timestamps of two reported rises.
module tb_clock_edge_monitor;
  localparam int SYNC = 2;
  localparam int TO   = 64;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          slow_in = 1'b0;
  logic          tick, tick_fall, period_valid, locked, timeout;
  logic [CW-1:0] period;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            samp_q[$];
  int            m;
  int            last_rise;
  bit            have_ref;
  bit            e_tick, e_fall, e_pv, e_locked, e_to;
  logic [CW-1:0] e_period;
  int            n_rise, n_tick_obs;

  always #5 clk = ~clk;

  clock_edge_monitor #(.SYNC_STAGES(SYNC), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .slow_in(slow_in), .tick(tick), .tick_fall(tick_fall),
    .period(period), .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  function automatic bit get_s(int k);
    int idx;
    idx = samp_q.size() - 1 - k;
    if (idx < 0) return 1'b0;
    return samp_q[idx];
  endfunction

  task automatic model_reset();
    samp_q.delete();
    m = 0; last_rise = 0; have_ref = 0;
    e_tick = 0; e_fall = 0; e_pv = 0; e_locked = 0; e_to = 0; e_period = '0;
    n_rise = 0; n_tick_obs = 0;
  endtask

  // Advance one clk edge, update the model from the sampled input, and settle 1 time unit.
  task automatic step();
    bit v, r, f;
    @(posedge clk);
    v = slow_in;
    m++;
    samp_q.push_back(v);
    if (samp_q.size() > 8) void'(samp_q.pop_front());
    r = get_s(SYNC) & ~get_s(SYNC + 1);
    f = ~get_s(SYNC) & get_s(SYNC + 1);
    e_tick = r;
    e_pv = 0;
`ifdef CLOCK_EDGE_MONITOR_FALL_EN
    e_fall = f;
`else
    e_fall = 0;
`endif
    if (r) begin
      n_rise++;
      e_to = 0;
      if (have_ref) begin
        e_period = CW'(m - last_rise);
        e_pv = 1;
        e_locked = 1;
      end
      have_ref = 1;
      last_rise = m;
    end else if (have_ref && (m - last_rise) == TO) begin
      e_to = 1;
      e_locked = 0;
      have_ref = 0;
    end
    #1;
    if (tick) n_tick_obs++;
  endtask

  task automatic test_reset();
    slow_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (tick_fall !== 1'b0) begin failures++; $display("FAIL reset_tick_fall got=%b exp=0", tick_fall); end
    checks++; if (period !== '0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", period_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_square20();
    for (int i = 0; i < 120; i++) begin
      slow_in = ((i % 20) < 10);
      step();
      if (i == 2) begin
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL first_tick_latency got=%b exp=1", tick); end
      end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL sq_tick cyc=%0d got=%b exp=%b", m, tick, e_tick); end
      checks++; if (tick_fall !== e_fall) begin failures++; $display("FAIL sq_tick_fall cyc=%0d got=%b exp=%b", m, tick_fall, e_fall); end
      checks++; if (period_valid !== e_pv) begin failures++; $display("FAIL sq_pv cyc=%0d got=%b exp=%b", m, period_valid, e_pv); end
      checks++; if (locked !== e_locked) begin failures++; $display("FAIL sq_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
      checks++; if (period !== e_period) begin failures++; $display("FAIL sq_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
    end
    checks++; if (n_tick_obs !== n_rise) begin failures++; $display("FAIL sq_tick_count got=%0d exp=%0d", n_tick_obs, n_rise); end
    checks++; if (period !== 32'd20) begin failures++; $display("FAIL sq_period_final got=%0d exp=20", period); end
  endtask

  task automatic test_timeout();
    bit saw_to_tick;
    slow_in = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++; if (timeout !== e_to) begin failures++; $display("FAIL to_timeout cyc=%0d got=%b exp=%b", m, timeout, e_to); end
      checks++; if (locked !== e_locked) begin failures++; $display("FAIL to_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
      checks++; if (period !== e_period) begin failures++; $display("FAIL to_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
    end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_level got=%b exp=1", timeout); end
    checks++; if (period !== 32'd20) begin failures++; $display("FAIL to_period_hold got=%0d exp=20", period); end
    saw_to_tick = 0;
    for (int i = 0; i < 60; i++) begin
      slow_in = ((i % 20) < 10);
      step();
      if (tick && !saw_to_tick) begin
        saw_to_tick = 1;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear_on_tick got=%b exp=0", timeout); end
      end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL rs_tick cyc=%0d got=%b exp=%b", m, tick, e_tick); end
      checks++; if (timeout !== e_to) begin failures++; $display("FAIL rs_timeout cyc=%0d got=%b exp=%b", m, timeout, e_to); end
      checks++; if (locked !== e_locked) begin failures++; $display("FAIL rs_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
      checks++; if (period_valid !== e_pv) begin failures++; $display("FAIL rs_pv cyc=%0d got=%b exp=%b", m, period_valid, e_pv); end
    end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rs_relock got=%b exp=1", locked); end
  endtask

  task automatic test_boundary64();
    int seg[$];
    bit saw64, to_before64;
    seg = '{10, 10, 10, 10, 10, 54, 10, 10, 10, 55, 10, 10, 10, 10};
    saw64 = 0; to_before64 = 0;
    foreach (seg[k]) begin
      for (int j = 0; j < seg[k]; j++) begin
        slow_in = (k % 2 == 0);
        step();
        if (period_valid && period == 32'd64) saw64 = 1;
        if (timeout && !saw64) to_before64 = 1;
        checks++; if (period_valid !== e_pv) begin failures++; $display("FAIL bd_pv cyc=%0d got=%b exp=%b", m, period_valid, e_pv); end
        checks++; if (period !== e_period) begin failures++; $display("FAIL bd_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
        checks++; if (timeout !== e_to) begin failures++; $display("FAIL bd_timeout cyc=%0d got=%b exp=%b", m, timeout, e_to); end
        checks++; if (locked !== e_locked) begin failures++; $display("FAIL bd_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
      end
    end
    checks++; if (saw64 !== 1'b1) begin failures++; $display("FAIL bd_period64_seen got=%b exp=1", saw64); end
    checks++; if (to_before64 !== 1'b0) begin failures++; $display("FAIL bd_no_timeout_at63 got=%b exp=0", to_before64); end
  endtask

  task automatic test_high_at_release();
    slow_in = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      slow_in = (i < 12) || (i >= 22 && i < 32);
      step();
      if (i == 2) begin
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL hr_tick_latency got=%b exp=1", tick); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL hr_first_pv got=%b exp=0", period_valid); end
      end
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL hr_tick cyc=%0d got=%b exp=%b", m, tick, e_tick); end
      checks++; if (period_valid !== e_pv) begin failures++; $display("FAIL hr_pv cyc=%0d got=%b exp=%b", m, period_valid, e_pv); end
      checks++; if (period !== e_period) begin failures++; $display("FAIL hr_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
    end
    checks++; if (period !== 32'd22) begin failures++; $display("FAIL hr_period_final got=%0d exp=22", period); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 65; i++) begin
      slow_in = ((i % 20) < 10);
      step();
    end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_pre_locked got=%b exp=1", locked); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ar_locked got=%b exp=0", locked); end
    checks++; if (period !== '0) begin failures++; $display("FAIL ar_period got=%0d exp=0", period); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL ar_tick got=%b exp=0", tick); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL ar_timeout got=%b exp=0", timeout); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 80; i++) begin
      slow_in = ((i % 20) >= 10);
      step();
      checks++; if (tick !== e_tick) begin failures++; $display("FAIL ar2_tick cyc=%0d got=%b exp=%b", m, tick, e_tick); end
      checks++; if (locked !== e_locked) begin failures++; $display("FAIL ar2_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
      checks++; if (period !== e_period) begin failures++; $display("FAIL ar2_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
    end
    checks++; if (period !== 32'd20) begin failures++; $display("FAIL ar_relock_period got=%0d exp=20", period); end
  endtask

  task automatic test_random();
    int len;
    bit lvl;
    lvl = 1'b0;
    for (int seg = 0; seg < 120; seg++) begin
      lvl = ~lvl;
      if (!lvl && $urandom_range(0, 7) == 0) len = $urandom_range(55, 75);
      else len = $urandom_range(SYNC + 1, 30);
      for (int j = 0; j < len; j++) begin
        slow_in = lvl;
        step();
        checks++; if (tick !== e_tick) begin failures++; $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", m, tick, e_tick); end
        checks++; if (tick_fall !== e_fall) begin failures++; $display("FAIL rnd_tick_fall cyc=%0d got=%b exp=%b", m, tick_fall, e_fall); end
        checks++; if (period_valid !== e_pv) begin failures++; $display("FAIL rnd_pv cyc=%0d got=%b exp=%b", m, period_valid, e_pv); end
        checks++; if (locked !== e_locked) begin failures++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", m, locked, e_locked); end
        checks++; if (timeout !== e_to) begin failures++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", m, timeout, e_to); end
        checks++; if (period !== e_period) begin failures++; $display("FAIL rnd_period cyc=%0d got=%0d exp=%0d", m, period, e_period); end
      end
    end
    checks++; if (n_tick_obs !== n_rise) begin failures++; $display("FAIL rnd_tick_count got=%0d exp=%0d", n_tick_obs, n_rise); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_square20();
    test_timeout();
    test_boundary64();
    test_high_at_release();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
